// File: rtl/transfer_bus_pkg.sv
// Shared types and helpers for the transfer bus: FSM state encoding and
// the select-width helper used to size source index fields.
package transfer_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Legacy-style constants mirroring the enum, used for the state register.
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_DRIVE  = 2'(DRIVE);
    localparam logic [1:0] ST_COMMIT = 2'(COMMIT);

    // Bits needed to index n sources; never narrower than one bit.
    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/transfer_bus_src_mux.sv
// Combinational source selector. Picks one word out of the flattened source
// vector and zero-extends sources marked narrow (8-bit) to the full width.
// An out-of-range index yields zero; the caller decides what that means.
module bus_src_mux
    import transfer_bus_pkg::*;
#(
    parameter int                   DATA_W      = 16,
    parameter int                   NUM_SRC     = 12,
    parameter logic [NUM_SRC-1:0]   NARROW_MASK = '0,
    parameter int                   SEL_W       = sel_width(NUM_SRC)
) (
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         word
);

    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

    // Select the indexed source word, masking narrow sources to their low byte.
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) begin
                if (NARROW_MASK[i]) begin
                    word = src_data[i*DATA_W +: DATA_W] & BYTE_MASK;
                end else begin
                    word = src_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/transfer_bus.sv
// Transfer bus: a request names a source and a destination set. The source
// word is loaded onto the registered bus on the DRIVE->COMMIT edge, and the
// destinations get a one-cycle load strobe during COMMIT.
//
// Handshake: a request is taken on a rising edge where xfer_valid and
// xfer_ready are both high; xfer_src and xfer_dst_mask are captured there.
// xfer_ready is low only in DRIVE, so a request held valid is accepted in
// COMMIT and transfers run back to back at one per two cycles.
module transfer_bus
    import transfer_bus_pkg::*;
#(
    parameter int                  DATA_W      = 16,
    parameter int                  NUM_SRC     = 12,
    parameter int                  NUM_DST     = 8,
    parameter logic [NUM_SRC-1:0]  NARROW_MASK = '0,
    parameter logic [DATA_W-1:0]   RESET_VALUE = DATA_W'(16'h0007),
    localparam int                 SRC_SEL_W   = sel_width(NUM_SRC)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    input  logic                       xfer_valid,
    input  logic [SRC_SEL_W-1:0]       xfer_src,
    input  logic [NUM_DST-1:0]         xfer_dst_mask,
    output logic                       xfer_ready,
    output logic [DATA_W-1:0]          bus_value,
    output logic [NUM_DST-1:0]         dst_load,
    output logic                       busy,
    output logic                       err_src,
    output logic [1:0]                 fsm_state
);

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [SRC_SEL_W-1:0] cap_src;
    logic [NUM_DST-1:0]   cap_mask;
    logic                 cap_err;
    logic                 accept;
    logic                 src_ok;
    logic [DATA_W-1:0]    mux_word;

    assign accept    = xfer_valid && xfer_ready;
    assign src_ok    = int'(cap_src) < NUM_SRC;
    assign fsm_state = state;

    bus_src_mux #(
        .DATA_W      (DATA_W),
        .NUM_SRC     (NUM_SRC),
        .NARROW_MASK (NARROW_MASK),
        .SEL_W       (SRC_SEL_W)
    ) u_src_mux (
        .src_data (src_data),
        .sel      (cap_src),
        .word     (mux_word)
    );

    // Next-state logic for the IDLE/DRIVE/COMMIT sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = accept ? ST_DRIVE : ST_IDLE;
            ST_DRIVE:  state_next = ST_COMMIT;
            ST_COMMIT: state_next = accept ? ST_DRIVE : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register plus request capture on each accepted handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cap_src  <= '0;
            cap_mask <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap_src  <= xfer_src;
                cap_mask <= xfer_dst_mask;
            end
        end
    end

    // Bus word loads only on the DRIVE->COMMIT edge and only for a valid
    // source; the error flag for the coming COMMIT is latched on that edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_value <= RESET_VALUE;
            cap_err   <= 1'b0;
        end else if (state == ST_DRIVE) begin
            cap_err <= !src_ok;
            if (src_ok) begin
                bus_value <= mux_word;
            end
        end
    end

    // Strobes and status are pure decodes of the registered state, so a new
    // request captured at the end of COMMIT cannot disturb the current strobe.
    always_comb begin
        xfer_ready = (state != ST_DRIVE);
        busy       = (state != ST_IDLE);
        err_src    = (state == ST_COMMIT) && cap_err;
        dst_load   = '0;
        if (state == ST_COMMIT && !cap_err) begin
            dst_load = cap_mask;
        end
    end

endmodule

// File: tb/tb_transfer_bus.sv
// Directed bench for transfer_bus: reset state, single transfer, narrow
// broadcast, back-to-back, empty mask, bad source index, reset mid-transfer.
module tb_transfer_bus;

    localparam int DATA_W  = 16;
    localparam int NUM_SRC = 12;
    localparam int NUM_DST = 8;
    localparam logic [NUM_SRC-1:0] NARROW = 12'b0000_0010_0000;

    logic                      clock;
    logic                      reset;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      xfer_valid;
    logic [3:0]                xfer_src;
    logic [NUM_DST-1:0]        xfer_dst_mask;
    logic                      xfer_ready;
    logic [DATA_W-1:0]         bus_value;
    logic [NUM_DST-1:0]        dst_load;
    logic                      busy;
    logic                      err_src;
    logic [1:0]                fsm_state;

    int checks   = 0;
    int failures = 0;

    transfer_bus #(
        .DATA_W      (DATA_W),
        .NUM_SRC     (NUM_SRC),
        .NUM_DST     (NUM_DST),
        .NARROW_MASK (NARROW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .src_data      (src_data),
        .xfer_valid    (xfer_valid),
        .xfer_src      (xfer_src),
        .xfer_dst_mask (xfer_dst_mask),
        .xfer_ready    (xfer_ready),
        .bus_value     (bus_value),
        .dst_load      (dst_load),
        .busy          (busy),
        .err_src       (err_src),
        .fsm_state     (fsm_state)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input logic [3:0] src, input logic [NUM_DST-1:0] mask);
        xfer_valid    = 1'b1;
        xfer_src      = src;
        xfer_dst_mask = mask;
    endtask

    initial begin
        reset         = 1'b1;
        xfer_valid    = 1'b0;
        xfer_src      = '0;
        xfer_dst_mask = '0;
        src_data      = '0;
        src_data[1*DATA_W +: DATA_W] = 16'hBEEF;
        src_data[2*DATA_W +: DATA_W] = 16'h1111;
        src_data[3*DATA_W +: DATA_W] = 16'h2222;
        src_data[5*DATA_W +: DATA_W] = 16'hFF3C;

        // Reset release then idle.
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_bus",   bus_value,  32'h0007);
        check("rst_load",  dst_load,   32'h0);
        check("rst_ready", xfer_ready, 32'h1);
        check("rst_busy",  busy,       32'h0);
        check("rst_state", fsm_state,  32'h0);

        // Single transfer, source 1 to destination 2.
        request(4'd1, 8'b0000_0100);
        step();
        xfer_valid = 1'b0;
        check("t1_drive_state", fsm_state,  32'h1);
        check("t1_drive_ready", xfer_ready, 32'h0);
        check("t1_drive_load",  dst_load,   32'h0);
        check("t1_drive_bus",   bus_value,  32'h0007);
        step();
        check("t1_commit_bus",  bus_value,  32'hBEEF);
        check("t1_commit_load", dst_load,   32'h04);
        check("t1_commit_busy", busy,       32'h1);
        step();
        check("t1_after_load",  dst_load,   32'h0);
        check("t1_after_state", fsm_state,  32'h0);
        check("t1_after_bus",   bus_value,  32'hBEEF);

        // Narrow source 5, broadcast to three destinations.
        request(4'd5, 8'b0100_0110);
        step();
        xfer_valid = 1'b0;
        step();
        check("t2_bus",  bus_value, 32'h003C);
        check("t2_load", dst_load,  32'h46);
        step();
        check("t2_after_load", dst_load, 32'h0);

        // Back-to-back: valid held across both requests.
        request(4'd2, 8'b0000_0001);
        step();
        check("t3_d1_ready", xfer_ready, 32'h0);
        request(4'd3, 8'b0000_0010);
        step();
        check("t3_c1_state", fsm_state,  32'h2);
        check("t3_c1_bus",   bus_value,  32'h1111);
        check("t3_c1_load",  dst_load,   32'h01);
        check("t3_c1_ready", xfer_ready, 32'h1);
        step();
        xfer_valid = 1'b0;
        check("t3_d2_state", fsm_state,  32'h1);
        check("t3_d2_ready", xfer_ready, 32'h0);
        check("t3_d2_load",  dst_load,   32'h0);
        check("t3_d2_bus",   bus_value,  32'h1111);
        step();
        check("t3_c2_bus",   bus_value,  32'h2222);
        check("t3_c2_load",  dst_load,   32'h02);
        step();
        check("t3_idle_busy", busy, 32'h0);

        // Empty mask still updates the bus.
        request(4'd1, 8'b0000_0000);
        step();
        xfer_valid = 1'b0;
        step();
        check("t4_bus",   bus_value, 32'hBEEF);
        check("t4_load",  dst_load,  32'h0);
        check("t4_state", fsm_state, 32'h2);
        step();

        // Out-of-range source index.
        request(4'd13, 8'hFF);
        step();
        xfer_valid = 1'b0;
        check("t5_drive_err", err_src, 32'h0);
        step();
        check("t5_err",  err_src,   32'h1);
        check("t5_load", dst_load,  32'h0);
        check("t5_bus",  bus_value, 32'hBEEF);
        step();
        check("t5_err_clear", err_src,   32'h0);
        check("t5_state",     fsm_state, 32'h0);

        // Reset asserted during DRIVE aborts the transfer.
        request(4'd2, 8'hFF);
        step();
        xfer_valid = 1'b0;
        check("t6_in_drive", fsm_state, 32'h1);
        reset = 1'b1;
        #1;
        check("t6_async_state", fsm_state, 32'h0);
        check("t6_async_bus",   bus_value, 32'h0007);
        check("t6_async_busy",  busy,      32'h0);
        step();
        check("t6_hold_load", dst_load, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_load", dst_load, 32'h0);
        end
        check("t6_ready", xfer_ready, 32'h1);
        check("t6_bus",   bus_value,  32'h0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
